// File: rtl/universal_shift_sequencer.sv
// universal_shift_sequencer
// Parametrised universal shift register driven by a valid/ready command port.
// HOLD, LOAD and CLR complete at the accept edge. Shift and rotate ops
// (SRL, SLL, ROR, ROL, ASR) run one bit per clock for cmd_count steps.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   cmd_valid  command offered
//   cmd_ready  block can accept a command this cycle (high in IDLE)
//   cmd_op     3-bit operation code
//   cmd_count  number of single-bit steps for shift/rotate ops
//   d          parallel load data, sampled only at a LOAD accept
//   sin        serial input, sampled live on every shift step
//   q          register contents
//   sout       last bit shifted or rotated out
//   busy       shift sequence in progress
//   done       one-cycle completion pulse
module universal_shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_LOAD = 3'b001,
    OP_SRL  = 3'b010,
    OP_SLL  = 3'b011,
    OP_ROR  = 3'b100,
    OP_ROL  = 3'b101,
    OP_ASR  = 3'b110,
    OP_CLR  = 3'b111
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state;
  state_e           state_next;
  op_e              op_in;
  op_e              op_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] q_reg;
  logic             sout_reg;
  logic             done_reg;
  logic             accept;
  logic             is_shift;
  logic             last_step;
  logic [WIDTH-1:0] step_q;
  logic             step_out;

  assign op_in     = op_e'(cmd_op);
  assign accept    = cmd_valid && cmd_ready;
  // Everything except HOLD, LOAD and CLR is a multi-cycle shift/rotate op.
  assign is_shift  = (op_in != OP_HOLD) && (op_in != OP_LOAD) && (op_in != OP_CLR);
  assign last_step = (cnt_reg == CNT_W'(1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: only a shift op with a non-zero count enters RUN,
  // and RUN is left on the edge that performs the final step.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept && is_shift && (cmd_count != '0)) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_step) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic: the handshake and busy flag depend on the state only.
  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE:    cmd_ready = 1'b1;
      RUN:     busy      = 1'b1;
      default: cmd_ready = 1'b0;
    endcase
  end

  // Single-step result for the latched op. sin is used live here so a
  // serial stream can change from one step to the next.
  always_comb begin
    step_q   = q_reg;
    step_out = sout_reg;
    case (op_reg)
      OP_SRL: begin
        step_q   = {sin, q_reg[WIDTH-1:1]};
        step_out = q_reg[0];
      end
      OP_SLL: begin
        step_q   = {q_reg[WIDTH-2:0], sin};
        step_out = q_reg[WIDTH-1];
      end
      OP_ROR: begin
        step_q   = {q_reg[0], q_reg[WIDTH-1:1]};
        step_out = q_reg[0];
      end
      OP_ROL: begin
        step_q   = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
        step_out = q_reg[WIDTH-1];
      end
      OP_ASR: begin
        step_q   = {q_reg[WIDTH-1], q_reg[WIDTH-1:1]};
        step_out = q_reg[0];
      end
      default: begin
        step_q   = q_reg;
        step_out = sout_reg;
      end
    endcase
  end

  // Datapath. The accept edge of a shift op only latches op and count;
  // bits move on the following RUN edges. done is a registered pulse that
  // is cleared every cycle unless a command completes on this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg    <= '0;
      sout_reg <= 1'b0;
      done_reg <= 1'b0;
      cnt_reg  <= '0;
      op_reg   <= OP_HOLD;
    end else begin
      done_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            case (op_in)
              OP_HOLD: done_reg <= 1'b1;
              OP_LOAD: begin
                q_reg    <= d;
                done_reg <= 1'b1;
              end
              OP_CLR: begin
                q_reg    <= '0;
                done_reg <= 1'b1;
              end
              default: begin
                if (cmd_count == '0) begin
                  done_reg <= 1'b1;
                end else begin
                  op_reg  <= op_in;
                  cnt_reg <= cmd_count;
                end
              end
            endcase
          end
        end
        RUN: begin
          q_reg    <= step_q;
          sout_reg <= step_out;
          cnt_reg  <= cnt_reg - CNT_W'(1);
          if (last_step) begin
            done_reg <= 1'b1;
          end
        end
        default: done_reg <= 1'b0;
      endcase
    end
  end

  assign q    = q_reg;
  assign sout = sout_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_universal_shift_sequencer.sv
// tb_universal_shift_sequencer
// Directed bench for universal_shift_sequencer with WIDTH=8, CNT_W=4.
// A table of single commands with hand-computed results is run first, then
// hand-written sequences cover mid-run reset, back-to-back loads, commands
// offered while busy and a live-changing serial input.
module tb_universal_shift_sequencer;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SRL  = 3'b010;
  localparam logic [2:0] OP_SLL  = 3'b011;
  localparam logic [2:0] OP_ROR  = 3'b100;
  localparam logic [2:0] OP_ROL  = 3'b101;
  localparam logic [2:0] OP_ASR  = 3'b110;
  localparam logic [2:0] OP_CLR  = 3'b111;

  typedef struct {
    logic [2:0]       op;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] d;
    logic             sin;
    logic [WIDTH-1:0] exp_q;
    logic             exp_sout;
  } vec_t;

  logic             clk;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [CNT_W-1:0] cmd_count;
  logic [WIDTH-1:0] d;
  logic             sin;
  logic [WIDTH-1:0] q;
  logic             sout;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;

  vec_t vecs [0:19];
  int   num_vecs;

  universal_shift_sequencer #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_count(cmd_count),
    .d(d),
    .sin(sin),
    .q(q),
    .sout(sout),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Offer one command for a single cycle, then watch busy/done until the
  // completion pulse, bounded so a stuck design still reaches the summary.
  task automatic applyStimulus(input vec_t v, input int idx);
    int  busy_cycles;
    int  latency;
    int  exp_busy;
    bit  seen;
    bit  overlap;
    busy_cycles = 0;
    latency     = 0;
    seen        = 1'b0;
    overlap     = 1'b0;
    exp_busy    = ((v.op inside {OP_SRL, OP_SLL, OP_ROR, OP_ROL, OP_ASR})) ? int'(v.count) : 0;
    @(negedge clk);
    checkOutput($sformatf("vec%0d ready", idx), 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = v.op;
    cmd_count = v.count;
    d         = v.d;
    sin       = v.sin;
    @(posedge clk);
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      latency++;
      if (busy) busy_cycles++;
      if (busy && done) overlap = 1'b1;
      if (done) seen = 1'b1;
    end
    checkOutput($sformatf("vec%0d done_seen", idx), 32'(seen), 32'd1);
    checkOutput($sformatf("vec%0d latency", idx), 32'(latency), 32'(exp_busy + 1));
    checkOutput($sformatf("vec%0d busy_cycles", idx), 32'(busy_cycles), 32'(exp_busy));
    checkOutput($sformatf("vec%0d busy_done_overlap", idx), 32'(overlap), 32'd0);
    checkOutput($sformatf("vec%0d q", idx), 32'(q), 32'(v.exp_q));
    checkOutput($sformatf("vec%0d sout", idx), 32'(sout), 32'(v.exp_sout));
    @(negedge clk);
    checkOutput($sformatf("vec%0d done_single", idx), 32'(done), 32'd0);
  endtask

  function automatic vec_t mk(input logic [2:0] op, input int count,
                              input logic [7:0] dv, input logic s,
                              input logic [7:0] eq, input logic es);
    vec_t v;
    v.op       = op;
    v.count    = CNT_W'(count);
    v.d        = dv;
    v.sin      = s;
    v.exp_q    = eq;
    v.exp_sout = es;
    return v;
  endfunction

  logic [WIDTH-1:0] ror_exp [0:3];
  logic [3:0]       sin_pat;

  initial begin
    vecs[0]  = mk(OP_LOAD, 0,  8'hA5, 1'b0, 8'hA5, 1'b0);
    vecs[1]  = mk(OP_SRL,  3,  8'h00, 1'b1, 8'hF4, 1'b1);
    vecs[2]  = mk(OP_LOAD, 5,  8'h81, 1'b0, 8'h81, 1'b1);
    vecs[3]  = mk(OP_ROL,  12, 8'h00, 1'b0, 8'h18, 1'b0);
    vecs[4]  = mk(OP_LOAD, 0,  8'h90, 1'b0, 8'h90, 1'b0);
    vecs[5]  = mk(OP_ASR,  2,  8'h00, 1'b1, 8'hE4, 1'b0);
    vecs[6]  = mk(OP_LOAD, 0,  8'h3C, 1'b0, 8'h3C, 1'b0);
    vecs[7]  = mk(OP_SLL,  0,  8'h00, 1'b1, 8'h3C, 1'b0);
    vecs[8]  = mk(OP_SLL,  3,  8'hFF, 1'b0, 8'hE0, 1'b1);
    vecs[9]  = mk(OP_ROR,  1,  8'h00, 1'b1, 8'h70, 1'b0);
    vecs[10] = mk(OP_SRL,  9,  8'h00, 1'b1, 8'hFF, 1'b1);
    vecs[11] = mk(OP_CLR,  4,  8'h55, 1'b0, 8'h00, 1'b1);
    vecs[12] = mk(OP_HOLD, 2,  8'h55, 1'b0, 8'h00, 1'b1);
    vecs[13] = mk(OP_LOAD, 0,  8'h80, 1'b0, 8'h80, 1'b1);
    vecs[14] = mk(OP_ASR,  10, 8'h00, 1'b0, 8'hFF, 1'b1);
    vecs[15] = mk(OP_LOAD, 0,  8'h7F, 1'b0, 8'h7F, 1'b1);
    vecs[16] = mk(OP_ASR,  15, 8'h00, 1'b1, 8'h00, 1'b0);
    vecs[17] = mk(OP_LOAD, 0,  8'h5A, 1'b0, 8'h5A, 1'b0);
    vecs[18] = mk(OP_ROR,  8,  8'h00, 1'b1, 8'h5A, 1'b0);
    vecs[19] = mk(OP_HOLD, 0,  8'h00, 1'b0, 8'h5A, 1'b0);
    num_vecs = 20;

    ror_exp[0] = 8'h09;
    ror_exp[1] = 8'h84;
    ror_exp[2] = 8'h42;
    ror_exp[3] = 8'h21;
    sin_pat    = 4'b1101;

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = OP_HOLD;
    cmd_count = '0;
    d         = '0;
    sin       = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state.
    @(negedge clk);
    checkOutput("reset q", 32'(q), 32'd0);
    checkOutput("reset sout", 32'(sout), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset ready", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < num_vecs; i++) begin
      applyStimulus(vecs[i], i);
    end

    // Reset in the middle of SRL N=5 after two steps.
    applyStimulus(mk(OP_LOAD, 0, 8'hA5, 1'b0, 8'hA5, 1'b0), 100);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = OP_SRL;
    cmd_count = CNT_W'(5);
    sin       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    checkOutput("midrst pre q", 32'(q), 32'hE9);
    checkOutput("midrst pre busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst q", 32'(q), 32'd0);
    checkOutput("midrst sout", 32'(sout), 32'd0);
    checkOutput("midrst busy", 32'(busy), 32'd0);
    checkOutput("midrst done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midrst ready", 32'(cmd_ready), 32'd1);
    repeat (6) @(negedge clk);
    checkOutput("midrst after q", 32'(q), 32'd0);
    checkOutput("midrst after busy", 32'(busy), 32'd0);
    checkOutput("midrst after done", 32'(done), 32'd0);

    // Back-to-back LOADs with cmd_valid held high.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = OP_LOAD;
    d         = 8'h11;
    @(posedge clk);
    #1;
    checkOutput("b2b q1", 32'(q), 32'h11);
    checkOutput("b2b done1", 32'(done), 32'd1);
    checkOutput("b2b ready", 32'(cmd_ready), 32'd1);
    d = 8'h22;
    @(posedge clk);
    #1;
    checkOutput("b2b q2", 32'(q), 32'h22);
    checkOutput("b2b done2", 32'(done), 32'd1);
    cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("b2b done_end", 32'(done), 32'd0);

    // LOAD offered during ROR N=4 is ignored until the done cycle.
    applyStimulus(mk(OP_LOAD, 0, 8'h12, 1'b0, 8'h12, 1'b0), 101);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = OP_ROR;
    cmd_count = CNT_W'(4);
    @(posedge clk);
    #1;
    cmd_op = OP_LOAD;
    d      = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("runload ready%0d", i), 32'(cmd_ready), 32'd0);
      @(posedge clk);
      #1;
      checkOutput($sformatf("runload q%0d", i), 32'(q), 32'(ror_exp[i]));
    end
    checkOutput("runload done", 32'(done), 32'd1);
    checkOutput("runload ready_done", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("runload q_load", 32'(q), 32'hFF);
    checkOutput("runload done_load", 32'(done), 32'd1);
    cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("runload done_end", 32'(done), 32'd0);

    // sin is sampled live on each step rather than latched at accept.
    applyStimulus(mk(OP_LOAD, 0, 8'h00, 1'b0, 8'h00, 1'b0), 102);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = OP_SRL;
    cmd_count = CNT_W'(4);
    sin       = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      sin       = sin_pat[i];
    end
    #1;
    checkOutput("livesin busy_pre", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("livesin q", 32'(q), 32'hD0);
    checkOutput("livesin sout", 32'(sout), 32'd0);
    checkOutput("livesin done", 32'(done), 32'd1);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/universal_shift_sequencer.md
Name: universal_shift_sequencer

Overview:
Parametrised universal shift register with a command-driven multi-step shift engine. It is the next generation of the team's 4-bit bidirectional shift register. Additions: WIDTH parameter, rotate and arithmetic modes, a programmable step count executed one bit per cycle, a valid/ready command handshake, busy/done status and a serial output. It sits between a control FSM and serial/parallel datapaths, such as SPI/UART framers and bit-serial arithmetic.

Parameters:
WIDTH, 8, register width in bits (>= 2)
CNT_W, 4, step-count width; must satisfy 2**CNT_W > WIDTH

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command offered
cmd_ready  output  1  block can accept a command this cycle
cmd_op  input  3  operation code, see Behaviour
cmd_count  input  CNT_W  number of single-bit steps for shift/rotate ops
d  input  WIDTH  parallel load data
sin  input  1  serial input, sampled on every shift step
q  output  WIDTH  register contents
sout  output  1  last bit shifted or rotated out
busy  output  1  shift sequence in progress
done  output  1  one-cycle pulse on command completion

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset (asserted at any time, including mid-sequence):
  - q=0, sout=0, busy=0, done=0.
  - FSM goes to IDLE; pending step count is discarded.
  - cmd_ready=1 once rst_n is deasserted.
- FSM states:
  - IDLE: cmd_ready=1, busy=0.
  - RUN: cmd_ready=0, busy=1.
- Accept: cmd_valid && cmd_ready at a rising edge. While in RUN, cmd_valid is ignored and the inputs have no effect.
- cmd_op encoding:
  - 000 HOLD: q unchanged.
  - 001 LOAD: q<=d.
  - 010 SRL: q<={sin,q[W-1:1]}; out bit q[0].
  - 011 SLL: q<={q[W-2:0],sin}; out bit q[W-1].
  - 100 ROR: q<={q[0],q[W-1:1]}; out bit q[0].
  - 101 ROL: q<={q[W-2:0],q[W-1]}; out bit q[W-1].
  - 110 ASR: q<={q[W-1],q[W-1:1]}; out bit q[0].
  - 111 CLR: q<=0.
- HOLD/LOAD/CLR:
  - Take effect at the accept edge; cmd_count is ignored.
  - FSM stays in IDLE; done=1 for the following cycle.
  - sout is unchanged.
- Shift ops (010–110) with cmd_count=N>0:
  - The accept edge latches the op and N. q is not modified at that edge. FSM goes to RUN.
  - Each RUN edge performs one step, sets sout to that step's out bit and decrements the remaining count.
  - The Nth step edge returns the FSM to IDLE and sets done=1 for one cycle.
  - Latency: N+1 edges from accept to done; busy high for exactly N cycles.
- Shift ops with cmd_count=0: no step, q and sout unchanged, done pulses in the next cycle, busy stays 0.
- N >= WIDTH is legal:
  - Rotates wrap (ROL by W+k equals ROL by k).
  - SRL/SLL fill entirely with sampled sin.
  - ASR saturates to all copies of the sign bit.
- Back-to-back: cmd_ready is high in the done cycle, so a new command may be accepted then. Throughput is 1 command per cycle for HOLD/LOAD/CLR.
- sin is sampled live on each step edge. It is not latched at accept.
- d is sampled only at LOAD accept.
- done is registered, never high for two consecutive cycles from a single command, and never asserted together with busy.

Test Plan:
- rst_n low for 2 cycles mid-RUN (SRL, N=5, after 2 steps) -> q=0, sout=0, busy=0, done=0 immediately (asynchronously). After release: cmd_ready=1, and no further steps occur.
- LOAD d=0xA5, then SRL N=3 with sin=1 (WIDTH=8):
  - q goes 0xD2, 0xE9, 0xF4 on successive edges; sout=1.
  - busy high 3 cycles; done pulses 4 edges after accept.
- LOAD 0x81, then ROL N=12 -> q=0x18, busy high 12 cycles, single done pulse. Separately, LOAD 0x90, then ASR N=2 -> q=0xE4, sout=0.
- SLL N=0 on q=0x3C -> q stays 0x3C, busy never asserts, done pulses in the next cycle.
- cmd_valid held high with LOAD 0x11 then LOAD 0x22 on consecutive cycles -> both accepted; q=0x11 then 0x22; done high 2 consecutive cycles, one per command.
- During RUN (ROR N=4), present LOAD d=0xFF with cmd_valid=1 -> cmd_ready=0, q follows only the rotate sequence. The LOAD is accepted in the done cycle if still held, giving q=0xFF one edge later.
